// File: rtl/mem_read_arbiter_if.sv
// Bundle of requester ports and Memory-side signals for mem_read_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/Memory view.
interface mem_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_rstrb;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_rvalid;
  logic              p0_rbusy;

  logic [ADDR_W-1:0] p1_addr;
  logic              p1_rstrb;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_rvalid;
  logic              p1_rbusy;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rstrb;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        proto_err;

  modport slave (
    input  p0_addr, p0_rstrb, p1_addr, p1_rstrb, mem_rdata,
    output p0_rdata, p0_rvalid, p0_rbusy,
    output p1_rdata, p1_rvalid, p1_rbusy,
    output mem_addr, mem_rstrb, proto_err
  );

  modport master (
    output p0_addr, p0_rstrb, p1_addr, p1_rstrb, mem_rdata,
    input  p0_rdata, p0_rvalid, p0_rbusy,
    input  p1_rdata, p1_rvalid, p1_rbusy,
    input  mem_addr, mem_rstrb, proto_err
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// Two-port read arbiter in front of a 1-cycle-latency read-only Memory (port 0 = load, port 1 = fetch).
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; otherwise port 0 wins every tie.
module mem_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             reset,
  mem_read_arbiter_if.slave bus
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_t;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit TIE_RR = 1'b1;
`else
  localparam bit TIE_RR = 1'b0;
`endif

  logic [1:0]        pend;
  logic [ADDR_W-1:0] paddr [2];
  logic              infl;
  port_t             infl_port;
  port_t             last_grant;
  logic [1:0]        proto_err;

  logic [1:0]        rstrb;
  logic [ADDR_W-1:0] req_addr [2];
  logic [1:0]        busy;
  logic [1:0]        rvalid;
  logic              any_pend;
  port_t             grant_port;
  port_t             rr_pick;
  logic [DATA_W-1:0] rdata;

  assign rstrb       = {bus.p1_rstrb, bus.p0_rstrb};
  assign req_addr[0] = bus.p0_addr;
  assign req_addr[1] = bus.p1_addr;

  // A port stays busy from capture until its data has been returned.
  assign busy[0]   = pend[0] | (infl & (infl_port == PORT0));
  assign busy[1]   = pend[1] | (infl & (infl_port == PORT1));
  assign rvalid[0] = infl & (infl_port == PORT0);
  assign rvalid[1] = infl & (infl_port == PORT1);
  assign any_pend  = |pend;
  assign rr_pick   = (last_grant == PORT0) ? PORT1 : PORT0;

  always_comb begin
    grant_port = PORT0;
    if (pend == 2'b10) begin
      grant_port = PORT1;
    end else if (pend == 2'b11) begin
      grant_port = TIE_RR ? rr_pick : PORT0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= 2'b00;
      paddr[0]   <= '0;
      paddr[1]   <= '0;
      infl       <= 1'b0;
      infl_port  <= PORT0;
      last_grant <= PORT1;
      proto_err  <= 2'b00;
    end else begin
      // Capture and grant never touch the same pend bit: capture needs pend clear, grant needs it set.
      for (int i = 0; i < 2; i++) begin
        if (rstrb[i]) begin
          if (busy[i]) begin
            proto_err[i] <= 1'b1;
          end else begin
            pend[i]  <= 1'b1;
            paddr[i] <= req_addr[i];
          end
        end
      end
      if (any_pend) begin
        pend[grant_port] <= 1'b0;
        infl             <= 1'b1;
        infl_port        <= grant_port;
        last_grant       <= grant_port;
      end else begin
        infl <= 1'b0;
      end
    end
  end

  assign rdata         = bus.mem_rdata;
  assign bus.mem_rstrb = any_pend;
  assign bus.mem_addr  = any_pend ? paddr[grant_port] : '0;
  assign bus.p0_rdata  = rdata;
  assign bus.p1_rdata  = rdata;
  assign bus.p0_rvalid = rvalid[0];
  assign bus.p1_rvalid = rvalid[1];
  assign bus.p0_rbusy  = busy[0];
  assign bus.p1_rbusy  = busy[1];
  assign bus.proto_err = proto_err;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with a behavioural 1-cycle-latency Memory.
// Tie-break expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_read_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] mem [256];

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [31:0] TIE2_FIRST  = 32'h1C;
  localparam logic [31:0] TIE2_SECOND = 32'h18;
`else
  localparam logic [31:0] TIE2_FIRST  = 32'h18;
  localparam logic [31:0] TIE2_SECOND = 32'h1C;
`endif

  mem_read_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural Memory: registered read, word-indexed, low address bits ignored.
  always @(posedge clk) begin
    if (bus.mem_rstrb) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.p0_rstrb = 1'b0;
    bus.p1_rstrb = 1'b0;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic apply_stimulus(input logic s0, input logic [31:0] a0,
                                input logic s1, input logic [31:0] a1);
    bus.p0_rstrb = s0;
    bus.p0_addr  = a0;
    bus.p1_rstrb = s1;
    bus.p1_addr  = a1;
  endtask

  task automatic check_output(input string tag, input logic rs, input logic [31:0] ad,
                              input logic v0, input logic v1, input logic b0, input logic b1);
    chk({tag, " mem_rstrb"}, {31'd0, bus.mem_rstrb}, {31'd0, rs});
    chk({tag, " mem_addr"},  bus.mem_addr, ad);
    chk({tag, " p0_rvalid"}, {31'd0, bus.p0_rvalid}, {31'd0, v0});
    chk({tag, " p1_rvalid"}, {31'd0, bus.p1_rvalid}, {31'd0, v1});
    chk({tag, " p0_rbusy"},  {31'd0, bus.p0_rbusy}, {31'd0, b0});
    chk({tag, " p1_rbusy"},  {31'd0, bus.p1_rbusy}, {31'd0, b1});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_output("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset proto_err", {30'd0, bus.proto_err}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a_out [2];
    bit          outst [2];
    bit          restrobe [2];
    int          issued [2];
    int          done [2];
    int          grants;
    bit          addr_ok;

    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 ^ (i * 32'h01030107);
    mem[4] = 32'hDEADBEEF;
    apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);

    // Test 1: single uncontended read
    $display("[TB] test 1: single read");
    do_reset();
    apply_stimulus(1'b1, 32'h10, 1'b0, 32'h0);
    settle(); check_output("t1 c0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); settle(); check_output("t1 c1", 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); settle(); check_output("t1 c2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1 p0_rdata", bus.p0_rdata, 32'hDEADBEEF);
    tick(); settle(); check_output("t1 c3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Tests 2 and 3: ties after reset, repeated, then a tie after a lone port-0 grant
    $display("[TB] test 2/3: ties");
    tick(); do_reset();
    apply_stimulus(1'b1, 32'h0, 1'b1, 32'h4);
    settle();
    tick(); settle(); check_output("t2 c1", 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); settle(); check_output("t2 c2", 1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t2 p0_rdata", bus.p0_rdata, mem[0]);
    tick(); settle(); check_output("t2 c3", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2 p1_rdata", bus.p1_rdata, mem[1]);
    tick(); apply_stimulus(1'b1, 32'h8, 1'b1, 32'hC); settle();
    tick(); settle(); check_output("t3 c5", 1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); settle(); check_output("t3 c6", 1'b1, 32'hC, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t3 p0_rdata", bus.p0_rdata, mem[2]);
    tick(); settle(); check_output("t3 c7", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t3 p1_rdata", bus.p1_rdata, mem[3]);
    tick(); apply_stimulus(1'b1, 32'h14, 1'b0, 32'h0); settle();
    tick(); settle(); check_output("t3 c9", 1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); settle(); check_output("t3 c10", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t3 c10 rdata", bus.p0_rdata, mem[5]);
    tick(); apply_stimulus(1'b1, 32'h18, 1'b1, 32'h1C); settle();
    tick(); settle(); check_output("t3 c12", 1'b1, TIE2_FIRST, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); settle();
    check_output("t3 c13", 1'b1, TIE2_SECOND, TIE2_FIRST == 32'h18, TIE2_FIRST == 32'h1C, 1'b1, 1'b1);
    chk("t3 c13 rdata", bus.p0_rdata, mem[TIE2_FIRST[9:2]]);
    tick(); settle();
    check_output("t3 c14", 1'b0, 32'h0, TIE2_SECOND == 32'h18, TIE2_SECOND == 32'h1C,
                 TIE2_SECOND == 32'h18, TIE2_SECOND == 32'h1C);
    chk("t3 c14 rdata", bus.p1_rdata, mem[TIE2_SECOND[9:2]]);

    // Test 4: restrobe while busy is dropped and flagged
    $display("[TB] test 4: protocol error");
    tick(); do_reset();
    apply_stimulus(1'b0, 32'h0, 1'b1, 32'h8); settle();
    tick(); apply_stimulus(1'b0, 32'h0, 1'b1, 32'h8); settle();
    check_output("t4 c1", 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4 c1 proto_err", {30'd0, bus.proto_err}, 32'h0);
    tick(); settle(); check_output("t4 c2", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t4 c2 rdata", bus.p1_rdata, mem[2]);
    chk("t4 c2 proto_err", {30'd0, bus.proto_err}, 32'h2);
    tick(); settle(); check_output("t4 c3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick(); settle();
    chk("t4 sticky proto_err", {30'd0, bus.proto_err}, 32'h2);

    // Test 5: asynchronous reset after the grant discards the read
    $display("[TB] test 5: reset mid-read");
    tick(); apply_stimulus(1'b1, 32'h10, 1'b0, 32'h0); settle();
    tick(); settle(); check_output("t5 c1", 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1 check_output("t5 async", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5 async proto_err", {30'd0, bus.proto_err}, 32'h0);
    #1 reset = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick(); settle(); check_output($sformatf("t5 c%0d", c), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick(); apply_stimulus(1'b1, 32'h10, 1'b0, 32'h0); settle();
    tick(); settle(); check_output("t5 c6", 1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); settle(); check_output("t5 c7", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5 c7 rdata", bus.p0_rdata, 32'hDEADBEEF);

    // Test 6: both ports restrobe right after each return, unaligned addresses
    $display("[TB] test 6: streaming reads");
    tick(); do_reset();
    grants = 0;
    for (int p = 0; p < 2; p++) begin
      a_out[p] = 32'h100 + 32'(p * 4) + 32'(p);
      outst[p] = 1'b1; restrobe[p] = 1'b0; issued[p] = 1; done[p] = 0;
    end
    apply_stimulus(1'b1, a_out[0], 1'b1, a_out[1]);
    for (int cyc = 0; cyc < 200 && (done[0] + done[1]) < 20; cyc++) begin
      settle();
      if (bus.mem_rstrb) begin
        grants++;
        addr_ok = (outst[0] && bus.mem_addr == a_out[0]) || (outst[1] && bus.mem_addr == a_out[1]);
        chk("t6 grant addr", {31'd0, addr_ok}, 32'h1);
      end
      if (bus.p0_rvalid) begin
        chk("t6 p0 outstanding", {31'd0, outst[0]}, 32'h1);
        chk("t6 p0 rdata", bus.p0_rdata, mem[a_out[0][9:2]]);
        outst[0] = 1'b0; done[0]++; restrobe[0] = issued[0] < 10;
      end
      if (bus.p1_rvalid) begin
        chk("t6 p1 outstanding", {31'd0, outst[1]}, 32'h1);
        chk("t6 p1 rdata", bus.p1_rdata, mem[a_out[1][9:2]]);
        outst[1] = 1'b0; done[1]++; restrobe[1] = issued[1] < 10;
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        if (restrobe[p]) begin
          a_out[p] = 32'h100 + 32'(p * 4) + 32'(issued[p] * 8) + 32'((issued[p] + p) % 4);
          outst[p] = 1'b1; issued[p]++; restrobe[p] = 1'b0;
          if (p == 0) begin
            bus.p0_rstrb = 1'b1; bus.p0_addr = a_out[0];
          end else begin
            bus.p1_rstrb = 1'b1; bus.p1_addr = a_out[1];
          end
        end
      end
    end
    chk("t6 reads done", 32'(done[0] + done[1]), 32'd20);
    chk("t6 grants", 32'(grants), 32'd20);
    chk("t6 proto_err", {30'd0, bus.proto_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
